y86_alu_arbiter: RTL and testbench
==================================

# y86_alu_arbiter

Shares the single Y86 ALU (addq/subq/andq/xorq) between two requesters: requester 0 is the execute stage, requester 1 is the secondary port (address/debug path). Arbitration is round-robin. The result is registered into one output stage with a valid/ready handshake. The block owns the architectural condition-code register (ZF, SF, OF) and updates it only for requests that ask for it.

## Interface
- W, 64, operand/result width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_ifun / req1_ifun  in  4  Y86 OPq function code
- req0_a / req1_a  in  W  valA
- req0_b / req1_b  in  W  valB
- req0_set_cc / req1_set_cc  in  1  update CC from this op
- rsp_valid  out  1  result stage holds data
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester index of result
- rsp_val  out  W  result
- rsp_err  out  1  ifun was illegal
- cc  out  3  {ZF,SF,OF}

## Operation
- ifun: 0 addq → b+a; 1 subq → b−a; 2 andq → b&a; 3 xorq → b^a. Codes 4–15 are illegal: result 0, rsp_err=1, CC untouched.
- Arithmetic is modulo 2^W, two's complement.
- ZF = (res==0). SF = res[W-1].
- OF for add: a[W-1]==b[W-1] && res[W-1]!=a[W-1].
- OF for sub: a[W-1]!=b[W-1] && res[W-1]!=b[W-1].
- OF for and/xor: 0.
- stage_free = !rsp_valid || rsp_ready.
- Arbitration uses a last-grant pointer `last`.
  - One requester valid: it is granted.
  - Both valid: grant the requester ≠ last.
  - reqN_ready = stage_free && grant==N. At most one ready is high per cycle; ready is never high without the matching valid.
- On accept (valid && ready):
  - Load rsp_val, rsp_err and rsp_id; set rsp_valid=1; last ← granted index.
  - If set_cc && !illegal: cc ← flags.
- On rsp_valid && rsp_ready with no new accept: rsp_valid ← 0.
- An accept in the same cycle as a drain overwrites the stage, giving back-to-back throughput.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_val=0, rsp_err=0, cc=3'b100 (ZF=1, SF=0, OF=0), last=1, so requester 0 wins the first contention.
- Latency: accept at edge k → rsp_valid and result visible after edge k; cc visible after edge k.
- Throughput: 1 op/cycle while rsp_ready=1.
- Backpressure: while rsp_valid && !rsp_ready:
  - Both reqN_ready are 0.
  - The output stage is stable: rsp_val, rsp_id and rsp_err do not change.
- Requesters hold ifun/a/b/set_cc stable until ready.
- Grant decision is combinational from valids, last and stage_free; no cycle is wasted on arbitration.
- Reset mid-operation: the held result is discarded, cc returns to 3'b100, and pending requests are re-arbitrated from last=1 after reset deasserts.
- Simultaneous drain + accept: the new result wins; rsp_valid stays 1.

## Structure
- Package y86_alu_pkg:
  - IFUN_ADD=4'h0, IFUN_SUB=4'h1, IFUN_AND=4'h2, IFUN_XOR=4'h3
  - CC index constants CC_ZF=2, CC_SF=1, CC_OF=0
  - CC_RESET=3'b100
- Sub-module y86_alu_core: combinational; inputs ifun, a, b; outputs res, zf, sf, of, illegal. It is reusable by the unarbitrated pipeline path.
- Top holds the arbiter, the `last` pointer, the output register and the CC register.

## Test plan
- Reset: assert rst with no traffic → rsp_valid=0, cc=3'b100, both readies 0.
- Single add with set_cc: req0 ifun=0, a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → next cycle rsp_val=64'h8000_0000_0000_0000, rsp_id=0, cc={0,1,1}.
- Sub and xor with flags:
  - req1 ifun=1, a=5, b=5, set_cc=1 → rsp_val=0, cc={1,0,0}.
  - Then req1 ifun=3, a=b=64'hFFFF_0000_FFFF_0000, set_cc=0 → rsp_val=0, cc unchanged.
- Contention with rsp_ready=1: req0 and req1 both valid for 4 cycles → grants alternate 0,1,0,1, and one rsp per cycle with matching rsp_id.
- Backpressure: rsp_ready=0 for 3 cycles while both request → both readies 0 and rsp_val stable; release → next grant follows round-robin.
- Illegal op and reset: req0 ifun=4, set_cc=1 → rsp_val=0, rsp_err=1, cc unchanged. Assert rst while rsp_valid=1 → rsp_valid drops immediately (async).

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared constants for the Y86 OPq ALU and the arbitrated ALU front end.
package y86_alu_pkg;

  localparam logic [3:0] IFUN_ADD = 4'h0;
  localparam logic [3:0] IFUN_SUB = 4'h1;
  localparam logic [3:0] IFUN_AND = 4'h2;
  localparam logic [3:0] IFUN_XOR = 4'h3;

  // Bit positions inside the {ZF,SF,OF} condition-code vector
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/y86_alu_core.sv
// Combinational Y86 OPq ALU: result, condition flags and illegal-ifun detect.
module y86_alu_core
  import y86_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [3:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         illegal
);

  always_comb begin
    res     = '0;
    of      = 1'b0;
    illegal = 1'b0;
    case (ifun)
      IFUN_ADD: begin
        res = b + a;
        of  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      IFUN_SUB: begin
        res = b - a;
        of  = (a[W-1] != b[W-1]) && (res[W-1] != b[W-1]);
      end
      IFUN_AND: res = b & a;
      IFUN_XOR: res = b ^ a;
      default:  illegal = 1'b1;
    endcase
    zf = (res == '0);
    sf = res[W-1];
  end

endmodule

// File: rtl/y86_alu_arbiter.sv
// Round-robin sharing of one Y86 ALU between two requesters, with a registered
// valid/ready result stage and the architectural condition-code register.
module y86_alu_arbiter
  import y86_alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_ifun,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_set_cc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_ifun,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_set_cc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_val,
  output logic         rsp_err,
  output logic [2:0]   cc
);

  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_val_q, rsp_val_d;
  logic         rsp_err_q, rsp_err_d;
  logic [2:0]   cc_q, cc_d;
  logic         last_q, last_d;

  logic         stage_free;
  logic         grant;
  logic         accept;
  logic [3:0]   alu_ifun;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_set_cc;
  logic [W-1:0] alu_res;
  logic         alu_zf, alu_sf, alu_of, alu_illegal;

  // Grant is purely combinational so an accept never costs an extra cycle.
  always_comb begin
    stage_free = !rsp_valid_q || rsp_ready;
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
    accept     = stage_free && (req0_valid || req1_valid);
    req0_ready = stage_free && req0_valid && !grant;
    req1_ready = stage_free && req1_valid && grant;
    alu_ifun   = grant ? req1_ifun   : req0_ifun;
    alu_a      = grant ? req1_a      : req0_a;
    alu_b      = grant ? req1_b      : req0_b;
    alu_set_cc = grant ? req1_set_cc : req0_set_cc;
  end

  y86_alu_core #(.W(W)) u_core (
    .ifun    (alu_ifun),
    .a       (alu_a),
    .b       (alu_b),
    .res     (alu_res),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of),
    .illegal (alu_illegal)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_val_d   = rsp_val_q;
    rsp_err_d   = rsp_err_q;
    cc_d        = cc_q;
    last_d      = last_q;
    if (accept) begin
      // A same-cycle drain is covered here too: the new result replaces the old.
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant;
      rsp_val_d   = alu_res;
      rsp_err_d   = alu_illegal;
      last_d      = grant;
      if (alu_set_cc && !alu_illegal) begin
        cc_d[CC_ZF] = alu_zf;
        cc_d[CC_SF] = alu_sf;
        cc_d[CC_OF] = alu_of;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_val_q   <= '0;
      rsp_err_q   <= 1'b0;
      cc_q        <= CC_RESET;
      last_q      <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_val_q   <= rsp_val_d;
      rsp_err_q   <= rsp_err_d;
      cc_q        <= cc_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_val   = rsp_val_q;
  assign rsp_err   = rsp_err_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_y86_alu_arbiter.sv
// Scoreboard bench for y86_alu_arbiter: a reference model predicts grants, results
// and flags; a negedge monitor compares every presented response against the queue.
module tb_y86_alu_arbiter;
  import y86_alu_pkg::*;

  localparam logic signed [64:0] MAXP = 65'sd9223372036854775807;
  localparam logic signed [64:0] MINN = -65'sd9223372036854775808;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_set_cc;
  logic [3:0]  req0_ifun;
  logic [63:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_set_cc;
  logic [3:0]  req1_ifun;
  logic [63:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_val;
  logic [2:0]  cc;

  y86_alu_arbiter #(.W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ifun(req0_ifun),
    .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ifun(req1_ifun),
    .req1_a(req1_a), .req1_b(req1_b), .req1_set_cc(req1_set_cc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_val(rsp_val), .rsp_err(rsp_err), .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [63:0] val;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference-model state
  logic       m_valid;
  logic       m_last;
  logic [2:0] m_cc;

  // Pending (held) requests per requester
  logic        p_v[2];
  logic [3:0]  p_f[2];
  logic [63:0] p_a[2];
  logic [63:0] p_b[2];
  logic        p_s[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Y86 OPq semantics via wide signed arithmetic; overflow is "true result out of range".
  function automatic void ref_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [2:0] fl, output logic bad);
    logic signed [64:0] wide;
    logic ov;
    bad = 1'b0;
    ov  = 1'b0;
    r   = '0;
    case (f)
      IFUN_ADD: begin
        wide = $signed(b) + $signed(a);
        ov   = (wide > MAXP) || (wide < MINN);
        r    = wide[63:0];
      end
      IFUN_SUB: begin
        wide = $signed(b) - $signed(a);
        ov   = (wide > MAXP) || (wide < MINN);
        r    = wide[63:0];
      end
      IFUN_AND: r = b & a;
      IFUN_XOR: r = b ^ a;
      default:  bad = 1'b1;
    endcase
    fl = {(r == 64'd0), r[63], ov};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_req(input int n, input logic [3:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic s);
    p_v[n] = 1'b1; p_f[n] = f; p_a[n] = a; p_b[n] = b; p_s[n] = s;
  endtask

  task automatic new_req(input int n);
    logic [3:0] f;
    logic [63:0] a;
    if ($urandom_range(0, 9) == 0) f = 4'($urandom_range(4, 15));
    else                           f = 4'($urandom_range(0, 3));
    a = pick();
    set_req(n, f, a, ($urandom_range(0, 4) == 0) ? a : pick(), 1'($urandom_range(0, 1)));
  endtask

  // One cycle, entered and left at posedge+1: drive, predict handshake, clock, check state.
  task automatic step(input logic rr);
    exp_t e;
    int g;
    logic free;
    logic [63:0] r;
    logic [2:0] fl;
    logic bad;
    #1;
    req0_valid = p_v[0]; req0_ifun = p_f[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_set_cc = p_s[0];
    req1_valid = p_v[1]; req1_ifun = p_f[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_set_cc = p_s[1];
    rsp_ready  = rr;
    #1;
    free = !m_valid || rr;
    g = -1;
    if (p_v[0] && p_v[1]) g = m_last ? 0 : 1;
    else if (p_v[0])      g = 0;
    else if (p_v[1])      g = 1;
    chk("req0_ready", 64'(req0_ready), 64'(free && g == 0));
    chk("req1_ready", 64'(req1_ready), 64'(free && g == 1));
    if (free && g >= 0) begin
      ref_op(p_f[g], p_a[g], p_b[g], r, fl, bad);
      e.id = g[0]; e.val = r; e.err = bad;
      exp_q.push_back(e);
      if (p_s[g] && !bad) m_cc = fl;
      m_last  = g[0];
      m_valid = 1'b1;
      p_v[g]  = 1'b0;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("cc", 64'(cc), 64'(m_cc));
  endtask

  // Monitor: a response consumed at the coming edge is popped; a held one must match the head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got id=%0d val=%h with nothing expected", rsp_id, rsp_val);
        end else if (rsp_ready) begin
          e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_val", rsp_val, e.val);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end else begin
          chk("hold_id", 64'(rsp_id), 64'(exp_q[0].id));
          chk("hold_val", rsp_val, exp_q[0].val);
          chk("hold_err", 64'(rsp_err), 64'(exp_q[0].err));
        end
      end
    end
  end

  initial begin
    logic [63:0] held;
    logic [2:0]  cc_before;
    int          guard;
    rst = 1'b1;
    req0_valid = 0; req0_ifun = 0; req0_a = 0; req0_b = 0; req0_set_cc = 0;
    req1_valid = 0; req1_ifun = 0; req1_a = 0; req1_b = 0; req1_set_cc = 0;
    rsp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 0; p_f[i] = 0; p_a[i] = 0; p_b[i] = 0; p_s[i] = 0;
    end
    m_valid = 0; m_last = 1; m_cc = 3'b100;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_cc", 64'(cc), 64'(3'b100));
    chk("reset_rsp_val", rsp_val, 64'd0);
    chk("reset_ready0", 64'(req0_ready), 64'd0);
    chk("reset_ready1", 64'(req1_ready), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Add with signed overflow into the sign bit
    set_req(0, IFUN_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    step(1'b1);
    chk("add_val", rsp_val, 64'h8000_0000_0000_0000);
    chk("add_id", 64'(rsp_id), 64'd0);
    chk("add_cc", 64'(cc), 64'(3'b011));

    set_req(1, IFUN_SUB, 64'd5, 64'd5, 1'b1);
    step(1'b1);
    chk("sub_val", rsp_val, 64'd0);
    chk("sub_cc", 64'(cc), 64'(3'b100));

    set_req(1, IFUN_XOR, 64'hFFFF_0000_FFFF_0000, 64'hFFFF_0000_FFFF_0000, 1'b0);
    step(1'b1);
    chk("xor_val", rsp_val, 64'd0);
    chk("xor_cc", 64'(cc), 64'(3'b100));

    // Contention with a free output stage alternates grants
    for (int i = 0; i < 4; i++) begin
      if (!p_v[0]) new_req(0);
      if (!p_v[1]) new_req(1);
      step(1'b1);
      chk("rr_id", 64'(rsp_id), 64'(i % 2));
    end

    // Backpressure: no readies, output frozen
    if (!p_v[0]) new_req(0);
    if (!p_v[1]) new_req(1);
    held = rsp_val;
    repeat (3) begin
      step(1'b0);
      chk("bp_hold_val", rsp_val, held);
    end
    step(1'b1);
    chk("bp_release_id", 64'(rsp_id), 64'd0);
    step(1'b1);
    step(1'b1);
    step(1'b1);

    // Illegal function code leaves flags alone
    cc_before = cc;
    set_req(0, 4'h4, 64'h1234, 64'h5678, 1'b1);
    step(1'b1);
    chk("ill_err", 64'(rsp_err), 64'd1);
    chk("ill_val", rsp_val, 64'd0);
    chk("ill_cc", 64'(cc), 64'(cc_before));
    step(1'b0);

    // Asynchronous reset while a result is held
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_cc", 64'(cc), 64'(3'b100));
    exp_q.delete();
    m_valid = 0; m_last = 1; m_cc = 3'b100;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    new_req(0);
    new_req(1);
    step(1'b1);
    chk("postrst_first_id", 64'(rsp_id), 64'd0);

    // Randomized traffic
    repeat (400) begin
      if (!p_v[0] && $urandom_range(0, 2) != 0) new_req(0);
      if (!p_v[1] && $urandom_range(0, 2) != 0) new_req(1);
      step($urandom_range(0, 3) != 0);
    end

    guard = 0;
    while ((p_v[0] || p_v[1] || m_valid) && guard < 20) begin
      step(1'b1);
      guard++;
    end
    chk("drain_done", 64'(p_v[0] || p_v[1] || m_valid), 64'd0);
    step(1'b1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
